// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Purpose  : Single-outstanding command-to-APB bridge (IDLE/SETUP/ACCESS).
//            Optional ACCESS-phase timeout when APB_MASTER_TIMEOUT_EN is defined.
// Revision : 1.0
// ============================================================================
module apb_master #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t state;
  logic   timeout_hit;

  assign cmd_ready = (state == IDLE);

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int                CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] wait_cnt;
  logic             err_q;

  // pready in the limit cycle wins, so only a low pready can time out
  assign timeout_hit = (state == ACCESS) && (wait_cnt == CNT_LIMIT) && !pready;
  assign rsp_err     = err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if (state == ACCESS && !pready && !timeout_hit) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (state == ACCESS && (pready || timeout_hit)) begin
        err_q <= !pready;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign rsp_err            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state  <= SETUP;
            psel   <= 1'b1;
            pwrite <= cmd_write;
            paddr  <= cmd_addr;
            pwdata <= cmd_write ? cmd_wdata : '0;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          penable <= 1'b1;
        end
        ACCESS: begin
          if (pready || timeout_hit) begin
            state     <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
          end
        end
        default: begin
          state   <= IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// tb_apb_master: random command stream against a memory-backed reference and
// APB slave model; a scoreboard queue holds expected responses and bus phases.
module tb_apb_master;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;

  apb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    bit          err;
    int          waits;
    int          acc;
    int          rc;
  } txn_t;

  txn_t          exp_q[$];
  logic [DW-1:0] ref_mem [2**AW];
  logic [DW-1:0] slv_mem [2**AW];
  int            checks = 0;
  int            errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // APB slave: pready after the transaction's chosen wait count, memory-backed
  int acc_cnt = 0;
  int cur_waits = 0;
  always @(negedge clk) begin
    if (rstn && psel && penable) begin
      cur_waits = (exp_q.size() != 0) ? exp_q[0].waits : 0;
      if (acc_cnt >= cur_waits) begin
        pready = 1'b1;
        if (pwrite) begin
          slv_mem[paddr] = pwdata;
          prdata = DW'($urandom);
        end else begin
          prdata = slv_mem[paddr];
        end
      end else begin
        pready = 1'b0;
        prdata = DW'($urandom);
      end
      acc_cnt++;
    end else begin
      acc_cnt = 0;
      pready  = 1'($urandom_range(0, 1));
      prdata  = DW'($urandom);
    end
  end

  // Scoreboard monitor
  txn_t t;
  bit   busy;
  always @(negedge clk) begin
    if (rstn) begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected 0 at cycle %0d", cyc);
        end else begin
          t = exp_q.pop_front();
          check("rsp_cycle", cyc, t.rc);
          check("rsp_rdata", rsp_rdata, t.rdata);
          check("rsp_err", rsp_err, t.err);
        end
      end else if (exp_q.size() != 0 && cyc > exp_q[0].rc) begin
        checks++; errors++;
        $display("FAIL rsp_missing: got none expected at cycle %0d", exp_q[0].rc);
        void'(exp_q.pop_front());
      end
      busy = (exp_q.size() != 0) && (cyc > exp_q[0].acc) && (cyc < exp_q[0].rc);
      check("psel", psel, busy);
      check("cmd_ready", cmd_ready, !busy);
      check("penable", penable, busy && (cyc >= exp_q[0].acc + 2));
      if (busy) begin
        check("paddr", paddr, exp_q[0].addr);
        check("pwrite", pwrite, exp_q[0].wr);
        check("pwdata", pwdata, exp_q[0].wr ? exp_q[0].wdata : '0);
      end
    end
  end

  // Drive a command from a negedge until accepted; returns at the next negedge
  task automatic issue(bit wr, logic [AW-1:0] a, logic [DW-1:0] d, int w);
    txn_t n;
    int   b = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready) begin
      @(negedge clk);
      b++;
      if (b > 100) begin
        checks++; errors++;
        $display("FAIL cmd_accept: got cmd_ready=0 expected 1 within 100 cycles");
        finish_run();
      end
    end
    n.wr = wr; n.addr = a; n.wdata = d; n.waits = w; n.acc = cyc; n.err = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
    n.err = (w > TO);
`endif
    n.rc    = cyc + 3 + (n.err ? TO : w);
    n.rdata = (wr || n.err) ? '0 : ref_mem[a];
    if (wr && !n.err) ref_mem[a] = d;
    exp_q.push_back(n);
    @(negedge clk);
  endtask

  task automatic idle(int k);
    cmd_valid = 1'b0;
    repeat (k) begin
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = AW'($urandom);
      cmd_wdata = DW'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int b = 0;
    while (exp_q.size() != 0 && b < 200) begin
      @(negedge clk);
      b++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) begin
      ref_mem[i] = DW'($urandom);
      slv_mem[i] = ref_mem[i];
    end
    repeat (3) @(negedge clk);
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    rstn = 1'b1;
    @(negedge clk);

    // Directed: write/read 0x10, waited read, back-to-back writes
    issue(1'b1, 8'h10, 8'hA5, 0);
    idle(3);
    issue(1'b0, 8'h10, 8'h00, 0);
    idle(3);
    issue(1'b0, 8'h10, 8'h3C, 3);
    idle(8);
    issue(1'b1, 8'h20, 8'h11, 0);
    issue(1'b1, 8'h21, 8'h22, 0);
    issue(1'b0, 8'h21, 8'h00, 1);
    idle(6);
    drain();

    // Abort mid-ACCESS with reset
    issue(1'b0, 8'h30, 8'h00, 6);
    cmd_valid = 1'b0;
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("abort_psel", psel, 0);
    check("abort_penable", penable, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_paddr", paddr, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idle(4);

    // Random stream, mixing back-to-back and gapped commands
    for (int i = 0; i < 300; i++) begin
      issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom),
            int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 6)));
    end
    idle(1);
    drain();

`ifdef APB_MASTER_TIMEOUT_EN
    // Ready exactly at the limit completes normally; stuck-low times out
    issue(1'b0, 8'h10, 8'h00, TO);
    idle(TO + 4);
    issue(1'b0, 8'h11, 8'h00, 1 << 20);
    idle(TO + 4);
    drain();
`endif

    finish_run();
  end
endmodule
`default_nettype wire
